// File: rtl/pacman_pkg.sv
// Shared types and maze constants for the Pac-Man mover and the wall renderer.
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    SCAN = 1'b0,
    DONE = 1'b1
  } frame_state_t;

  localparam int MAZE_W = 380;
  localparam int MAZE_H = 432;
  localparam int BORDER = 8;

  // Raster position of maze (0,0): custom offset plus blanking.
  localparam logic [9:0] OFFSETH_DEF = 10'd274;
  localparam logic [9:0] OFFSETV_DEF = 10'd58;

endpackage

// File: rtl/pacman_mover_edge_probe.sv
// Combinational test of whether a maze pixel lies in the 1-deep strip bordering
// one side of Pac-Man's box.
module edge_probe
  import pacman_pkg::*;
#(
  parameter dir_t DIR  = UP,
  parameter int   HALF = 10,
  parameter int   STEP = 1
) (
  input  logic        [9:0]  pac_x_i,
  input  logic        [9:0]  pac_y_i,
  input  logic signed [10:0] mx_i,
  input  logic signed [10:0] my_i,
  output logic               in_strip_o
);

  localparam logic signed [11:0] H   = 12'(HALF);
  localparam logic signed [11:0] S   = 12'(STEP);
  localparam logic signed [11:0] ONE = 12'sd1;

  logic signed [11:0] px, py, x, y;
  logic signed [11:0] x_lo, x_hi, y_lo, y_hi;

  always_comb begin
    px   = $signed({2'b00, pac_x_i});
    py   = $signed({2'b00, pac_y_i});
    x    = {mx_i[10], mx_i};
    y    = {my_i[10], my_i};
    x_lo = px - H;
    x_hi = px + H;
    y_lo = py - H;
    y_hi = py + H;
    case (DIR)
      UP: begin
        y_lo = py - H - S;
        y_hi = py - H - ONE;
      end
      DOWN: begin
        y_lo = py + H + ONE;
        y_hi = py + H + S;
      end
      LEFT: begin
        x_lo = px - H - S;
        x_hi = px - H - ONE;
      end
      RIGHT: begin
        x_lo = px + H + ONE;
        x_hi = px + H + S;
      end
      default: ;
    endcase
    // Off-maze raster positions (negative coordinates) never count as a hit.
    in_strip_o = !x[11] && !y[11] &&
                 (x >= x_lo) && (x <= x_hi) && (y >= y_lo) && (y <= y_hi);
  end

endmodule

// File: rtl/pacman_mover.sv
// Pac-Man position owner: samples wall pixels around the box during the scan and
// moves once per frame on the UPDATE_V line.
//
//   state | meaning
//   SCAN  | armed; accumulating wall flags, waiting for the UPDATE_V line
//   DONE  | update done this frame; waiting for vCount==0 to re-arm
module pacman_mover
  import pacman_pkg::*;
#(
  parameter logic [9:0] OFFSETH  = OFFSETH_DEF,
  parameter logic [9:0] OFFSETV  = OFFSETV_DEF,
  parameter int         HALF     = 10,
  parameter int         STEP     = 1,
  parameter logic [9:0] START_X  = 10'd190,
  parameter logic [9:0] START_Y  = 10'd318,
  parameter logic [9:0] UPDATE_V = 10'd520
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bright,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       wallFill,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic [9:0] pacX,
  output logic [9:0] pacY,
  output dir_t       dir,
  output logic       moving,
  output logic       frame_tick
);

  localparam logic signed [11:0] S     = 12'(STEP);
  localparam logic signed [11:0] X_MIN = 12'(HALF + BORDER);
  localparam logic signed [11:0] X_MAX = 12'(MAZE_W - BORDER - HALF);
  localparam logic signed [11:0] Y_MIN = 12'(HALF + BORDER);
  localparam logic signed [11:0] Y_MAX = 12'(MAZE_H - BORDER - HALF);

  frame_state_t state_q, state_d;
  logic [9:0]   x_q, x_d, y_q, y_d;
  dir_t         dir_q, dir_d, req_q, req_d;
  logic [3:0]   blocked_q, blocked_d;
  logic         moving_q, moving_d, tick_q, tick_d;

  logic signed [10:0] mx, my;
  logic [3:0]         hit;
  logic               update, go;
  dir_t               mv;
  logic signed [11:0] nx, ny;

  assign mx = $signed({1'b0, hCount}) - $signed({1'b0, OFFSETH});
  assign my = $signed({1'b0, vCount}) - $signed({1'b0, OFFSETV});

  for (genvar g = 0; g < 4; g++) begin : g_probe
    edge_probe #(
      .DIR  (dir_t'(g)),
      .HALF (HALF),
      .STEP (STEP)
    ) u_probe (
      .pac_x_i    (x_q),
      .pac_y_i    (y_q),
      .mx_i       (mx),
      .my_i       (my),
      .in_strip_o (hit[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    req_d     = req_q;
    blocked_d = blocked_q;
    moving_d  = moving_q;
    tick_d    = 1'b0;
    go        = 1'b0;
    mv        = dir_q;
    nx        = $signed({2'b00, x_q});
    ny        = $signed({2'b00, y_q});
    update    = (state_q == SCAN) && (vCount == UPDATE_V);

    case ({btnU, btnD, btnL, btnR})
      4'b1000: req_d = UP;
      4'b0100: req_d = DOWN;
      4'b0010: req_d = LEFT;
      4'b0001: req_d = RIGHT;
      default: ;
    endcase

    case (state_q)
      SCAN: if (update) state_d = DONE;
      DONE: if (vCount == 10'd0) state_d = SCAN;
      default: state_d = SCAN;
    endcase

    if (state_q == DONE && vCount == 10'd0) blocked_d = '0;
    else if (bright && wallFill)            blocked_d = blocked_q | hit;

    // The decision uses flags accumulated before this cycle, not this cycle's sample.
    if (update) begin
      tick_d = 1'b1;
      if (!blocked_q[req_q]) begin
        dir_d    = req_q;
        mv       = req_q;
        go       = 1'b1;
        moving_d = 1'b1;
      end else if (!blocked_q[dir_q]) begin
        mv       = dir_q;
        go       = 1'b1;
        moving_d = 1'b1;
      end else begin
        moving_d = 1'b0;
      end
    end

    case (mv)
      UP:      ny = ny - S;
      DOWN:    ny = ny + S;
      LEFT:    nx = nx - S;
      RIGHT:   nx = nx + S;
      default: ;
    endcase
    if (nx < X_MIN) nx = X_MIN;
    if (nx > X_MAX) nx = X_MAX;
    if (ny < Y_MIN) ny = Y_MIN;
    if (ny > Y_MAX) ny = Y_MAX;

    if (go) begin
      x_d = nx[9:0];
      y_d = ny[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      x_q       <= START_X;
      y_q       <= START_Y;
      dir_q     <= LEFT;
      req_q     <= LEFT;
      blocked_q <= '0;
      moving_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      req_q     <= req_d;
      blocked_q <= blocked_d;
      moving_q  <= moving_d;
      tick_q    <= tick_d;
    end
  end

  assign pacX       = x_q;
  assign pacY       = y_q;
  assign dir        = dir_q;
  assign moving     = moving_q;
  assign frame_tick = tick_q;

endmodule
